// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: word-addressed RAM behind an IDLE/WAIT/RESP handshake.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned requests on Mem_Err and suppress their effects.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_Data,
  output logic        Mem_Ready,
  output logic        Mem_Busy,
  output logic        Mem_Err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_data;
  logic             lat_write;
  logic             lat_misalign;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             in_misalign;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_data;
  logic             cur_write;
  logic             cur_misalign;

`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr;
  assign in_misalign = |Address[1:0];
  assign unused_addr = ^Address[31:IDX_W+2];
`else
  logic unused_addr;
  assign in_misalign = 1'b0;
  assign unused_addr = ^{Address[31:IDX_W+2], Address[1:0]};
`endif

  assign accept     = (state == ST_IDLE) && (MemRead || MemWrite);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign Mem_Busy   = (state != ST_IDLE);

  // With zero wait states RESP is entered on the acceptance edge, so the live inputs are used
  always_comb begin
    cur_idx      = lat_idx;
    cur_data     = lat_data;
    cur_write    = lat_write;
    cur_misalign = lat_misalign;
    if (state == ST_IDLE) begin
      cur_idx      = Address[IDX_W+1:2];
      cur_data     = Write_Data;
      cur_write    = MemWrite;
      cur_misalign = in_misalign;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      lat_idx      <= '0;
      lat_data     <= 32'd0;
      lat_write    <= 1'b0;
      lat_misalign <= 1'b0;
      Read_Data    <= 32'd0;
      Mem_Ready    <= 1'b0;
      Mem_Err      <= 1'b0;
    end else begin
      Mem_Ready <= 1'b0;
      Mem_Err   <= 1'b0;
      if (enter_resp) begin
        Read_Data <= cur_misalign ? 32'd0 : mem[cur_idx];
        Mem_Ready <= 1'b1;
        Mem_Err   <= cur_misalign;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_idx      <= Address[IDX_W+1:2];
            lat_data     <= Write_Data;
            lat_write    <= MemWrite;
            lat_misalign <= in_misalign;
            wait_cnt     <= WAIT_LOAD;
            state        <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Store commits on the RESP-entry edge; the read above sees the pre-write word
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !cur_misalign) mem[cur_idx] <= cur_data;
  end

endmodule
